// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control constants, FSM state encoding and the priority-mask helper.
package pipe_hazard_ctrl_pkg;

  localparam int PIPE_CTRL_STAGES   = 5;
  localparam int PIPE_CTRL_WDOG_CYC = 64;
  localparam int PIPE_MAX_STAGES    = 32;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTING = 2'd1,
    ST_HALTED  = 2'd2
  } ctrl_state_e;

  // Highest set bit becomes a thermometer: every bit at or below it is set.
  function automatic logic [PIPE_MAX_STAGES-1:0] thermo_mask(input logic [PIPE_MAX_STAGES-1:0] v);
    logic acc;
    acc = 1'b0;
    thermo_mask = '0;
    for (int i = PIPE_MAX_STAGES - 1; i >= 0; i--) begin
      acc            = acc | v[i];
      thermo_mask[i] = acc;
    end
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_wdog.sv
// Stall watchdog: counts consecutive stalled cycles, saturates, raises a sticky error.
module pipe_wdog #(
  parameter int WDOG_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic hold,
  output logic err
);

  localparam int CW = $clog2(WDOG_CYC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      // Error lags the counter reaching the limit by one cycle.
      if (cnt == CW'(WDOG_CYC)) err <= 1'b1;
      if (!hold) begin
        if (!inc)                      cnt <= '0;
        else if (cnt != CW'(WDOG_CYC)) cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/bubble masks, debug halt FSM, stall watchdog.
// Optional PIPE_CTRL_PERF_EN adds stall-cycle and flush-cycle performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int STAGES   = PIPE_CTRL_STAGES,
  parameter int WDOG_CYC = PIPE_CTRL_WDOG_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req,
  input  logic [STAGES-1:0] flush_req,
  input  logic              halt_req,
  input  logic              resume,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] flush,
  output logic [STAGES-1:0] bubble,
  output logic              halted,
  output logic              wdog_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cyc,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int P = PIPE_MAX_STAGES;

  ctrl_state_e       state;
  logic [STAGES-1:0] flush_run, stall_eff, stall_run;

  // Stages younger than the oldest redirecting stage are discarded and may not stall.
  assign flush_run = STAGES'(thermo_mask(P'(flush_req) >> 1));
  assign stall_eff = stall_req & ~flush_run;
  assign stall_run = (STAGES'(thermo_mask(P'(stall_eff)))
                     | {{(STAGES-1){1'b0}}, state == ST_HALTING})
                     & ~flush_run;

  always_comb begin
    stall = '0;
    flush = '0;
    if (rst) begin
      stall = '1;
      flush = '1;
    end else if (state == ST_HALTED) begin
      stall = '1;
    end else begin
      stall = stall_run;
      flush = flush_run;
    end
  end

  assign bubble = {stall[STAGES-2:0], 1'b0} & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_RUN: if (halt_req) state <= ST_HALTING;
        ST_HALTING: begin
          if (!halt_req) begin
            state <= ST_RUN;
          end else if (stall_req[STAGES-1:1] == '0) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (resume) begin
            state  <= ST_RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= ST_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  pipe_wdog #(.WDOG_CYC(WDOG_CYC)) u_wdog (
    .clk  (clk),
    .rst  (rst),
    .inc  ((|stall) & ~(|flush)),
    .hold (state == ST_HALTED),
    .err  (wdog_err)
  );

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (|stall)     perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (|flush_req) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 5, number of pipeline stages; stage 0 is youngest (fetch).
REQ-002 SHALL have parameter WDOG_CYC, default 64, stall-watchdog limit in cycles (range 2..65535).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port stall_req  input  STAGES  bit i: stage i cannot advance this cycle.
REQ-006 SHALL have port flush_req  input  STAGES  bit i: stage i redirects; all younger stages are discarded.
REQ-007 SHALL have port halt_req  input  1  debug halt request, level.
REQ-008 SHALL have port resume  input  1  debug resume, single-cycle pulse.
REQ-009 SHALL have port stall  output  STAGES  bit i: hold stage i register.
REQ-010 SHALL have port flush  output  STAGES  bit i: invalidate stage i register.
REQ-011 SHALL have port bubble  output  STAGES  bit i: stage i loads a bubble (stage i-1 stalled, stage i not).
REQ-012 SHALL have port halted  output  1  registered halt acknowledge.
REQ-013 SHALL have port wdog_err  output  1  sticky stall-timeout flag.

Function
REQ-014 SHALL compute stall, flush, bubble combinationally from current inputs and registered state (zero latency).
REQ-015 SHALL set stall[k]=1 for all k<=m, m = highest index with effective stall_req set; stall=0 when none.
REQ-016 SHALL set flush[k]=1 for all k<j, j = highest index with flush_req set; flush[j] and older stay 0.
REQ-017 SHALL ignore stall_req[k] for k<j when flush_req[j] is set (flushed stages cannot stall).
REQ-018 SHALL give flush priority over stall for the same stage: flush[k]=1 forces stall[k]=0.
REQ-019 SHALL assert bubble[i] = stall[i-1] & ~stall[i] & ~flush[i] for i>=1; bubble[0]=0.
REQ-020 SHALL implement FSM RUN, HALTING, HALTED.
REQ-021 RUN->HALTING when halt_req=1; HALTING stalls stage 0 only, letting older stages drain.
REQ-022 HALTING->HALTED when no stall_req among stages 1..STAGES-1 and halt_req still 1; HALTING->RUN if halt_req drops.
REQ-023 HALTED SHALL stall all stages, flush none, ignore stall_req/flush_req; halted=1 registered while in HALTED.
REQ-024 HALTED->RUN on resume=1; resume in RUN/HALTING SHALL be ignored; halt_req and resume both 1 in HALTED -> RUN.
REQ-025 SHALL count consecutive cycles with stall[STAGES-1]... any stall bit set and no flush; counter clears on a stall-free cycle, saturates at WDOG_CYC.
REQ-026 SHALL set wdog_err one cycle after counter reaches WDOG_CYC; held until reset; HALTED cycles SHALL NOT count.

Reset
REQ-027 On rst=1 at a clock edge SHALL enter RUN, clear watchdog counter, halted=0, wdog_err=0, perf counters 0.
REQ-028 During rst stall, flush, bubble SHALL be all-ones, all-ones, zero respectively (pipeline held invalid).
REQ-029 Reset mid-HALTING or mid-HALTED SHALL abort the halt with no halted pulse.

Configuration
REQ-030 Macro PIPE_CTRL_PERF_EN defined: adds outputs perf_stall_cyc and perf_flush_cnt, 32 bits each, wrapping, counting cycles with any stall bit and cycles with any flush_req bit.
REQ-031 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-032 FSM state encoding and PIPE_CTRL default parameter constants SHALL live in the shared define package with other pipeline constants.
REQ-033 Watchdog SHALL be a sub-module pipe_wdog (counter, saturate, sticky flag), parametrised by WDOG_CYC.
REQ-034 Priority masks (highest-set-bit to thermometer) SHALL be a function, not a sub-module.

Verification (STAGES=5, WDOG_CYC=4)
REQ-035 stall_req=5'b00100 -> stall=5'b00111, bubble=5'b01000, flush=0.
REQ-036 stall_req=5'b00010, flush_req=5'b00100 same cycle -> flush=5'b00011, stall=0, bubble=0.
REQ-037 halt_req=1 with stall_req[3]=1 for 2 cycles -> HALTING 2 cycles, halted=1 on 4th edge, stall=5'b11111; resume pulse -> halted=0 next edge.
REQ-038 stall_req=5'b00001 held 5 cycles -> wdog_err rises after 5th edge, stays 1 after stall_req cleared, clears only on rst.
REQ-039 rst asserted while HALTED -> next cycle state RUN, halted=0, stall=0 with stall_req=0.
REQ-040 PIPE_CTRL_PERF_EN build: 3 stall cycles and 2 flush cycles -> perf_stall_cyc=3, perf_flush_cnt=2.
